issue_scoreboard: RTL and testbench



---
 rtl/instr_type.sv | 14 +
 rtl/issue_scoreboard_pkg.sv | 26 ++
 rtl/register_file_params.sv | 6 +
 rtl/scoreboard_table.sv | 74 +++++++
 rtl/issue_scoreboard.sv | 139 +++++++++++++
 tb/tb_issue_scoreboard.sv | 261 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/instr_type.sv
// Decoded instruction kinds carried through the pipeline.
package instr_type;

    typedef enum logic [2:0] {
        Invalid = 3'd0,
        Alu     = 3'd1,
        AluImm  = 3'd2,
        Load    = 3'd3,
        Store   = 3'd4,
        Branch  = 3'd5,
        Jump    = 3'd6
    } instr_kind_t;

endpackage

// File: rtl/issue_scoreboard_pkg.sv
// Types and helpers for the issue scoreboard: slot FSM states, the
// pending-counter width function and the one-entry issue slot record.
package issue_scoreboard_pkg;

    import instr_type::*;
    import register_file_params::*;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Bits needed to count 0..max_pending outstanding writes.
    function automatic int pend_count_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    typedef struct packed {
        instr_kind_t                          kind;
        logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rs1;
        logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rs2;
        logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd;
        logic                                 wr;
    } slot_t;

endpackage

// File: rtl/register_file_params.sv
// Register file geometry shared by decode, scoreboard and execute.
package register_file_params;

    localparam int REGISTER_DESCRIPTOR_WIDTH = 5;

endpackage

// File: rtl/scoreboard_table.sv
// Per-register pending-write counters. x0 is never tracked. Produces the
// effective count (with same-cycle writeback bypass) for three read ports
// and applies reserve / writeback / flush-release updates each cycle.
module scoreboard_table
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_PENDING = 3,
    parameter int ADDR_WIDTH  = 5,
    localparam int COUNT_WIDTH = pend_count_width(MAX_PENDING)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  addr_a,
    input  logic [ADDR_WIDTH-1:0]  addr_b,
    input  logic [ADDR_WIDTH-1:0]  addr_c,
    output logic [COUNT_WIDTH-1:0] eff_a,
    output logic [COUNT_WIDTH-1:0] eff_b,
    output logic [COUNT_WIDTH-1:0] eff_c,
    input  logic                   inc_en,
    input  logic [ADDR_WIDTH-1:0]  inc_addr,
    input  logic                   dec_en,
    input  logic [ADDR_WIDTH-1:0]  dec_addr,
    input  logic                   rel_en,
    input  logic [ADDR_WIDTH-1:0]  rel_addr,
    output logic                   sb_error
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [COUNT_WIDTH-1:0] pend      [1:NUM_REGS-1];
    logic [COUNT_WIDTH-1:0] pend_next [1:NUM_REGS-1];
    logic [COUNT_WIDTH-1:0] pend_full [0:NUM_REGS-1];
    logic                   wb_underflow;

    // x0 reads as a permanently idle register.
    assign pend_full[0] = '0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_full
        assign pend_full[g] = pend[g];
    end

    // A writeback landing this cycle already counts as released for hazards.
    assign eff_a = pend_full[addr_a] - COUNT_WIDTH'(dec_en && dec_addr == addr_a && pend_full[addr_a] != '0);
    assign eff_b = pend_full[addr_b] - COUNT_WIDTH'(dec_en && dec_addr == addr_b && pend_full[addr_b] != '0);
    assign eff_c = pend_full[addr_c] - COUNT_WIDTH'(dec_en && dec_addr == addr_c && pend_full[addr_c] != '0);

    assign wb_underflow = dec_en && dec_addr != '0 && pend_full[dec_addr] == '0;

    // Next count per register: +reserve, -writeback, -flush release, never below zero.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin : upd
            logic inc_hit;
            logic dec_hit;
            logic rel_hit;
            inc_hit = inc_en && inc_addr == ADDR_WIDTH'(r);
            dec_hit = dec_en && dec_addr == ADDR_WIDTH'(r) && pend[r] != '0;
            rel_hit = rel_en && rel_addr == ADDR_WIDTH'(r) && pend[r] > COUNT_WIDTH'(dec_hit);
            pend_next[r] = pend[r] + COUNT_WIDTH'(inc_hit) - COUNT_WIDTH'(dec_hit) - COUNT_WIDTH'(rel_hit);
        end
    end

    // Counter state and the sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend     <= '{default: '0};
            sb_error <= 1'b0;
        end else begin
            pend <= pend_next;
            if (wb_underflow) begin
                sb_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller between decode and execute: hazard detection against the
// pending-write table, a one-entry issue slot with valid/ready handshake,
// and reservation release on writeback and flush.
// Optional statistics counters are built when ISSUE_SCOREBOARD_STATS_EN is defined.
module issue_scoreboard
    import instr_type::*;
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_PENDING               = 3,
    parameter int REGISTER_DESCRIPTOR_WIDTH = register_file_params::REGISTER_DESCRIPTOR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 dec_valid,
    output logic                                 dec_ready,
    input  instr_kind_t                          instr_kind,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rs1_addr,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rs2_addr,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr,
    input  logic                                 uses_rs1,
    input  logic                                 uses_rs2,
    input  logic                                 write_reserve,
    output logic                                 issue_valid,
    input  logic                                 issue_ready,
    output instr_kind_t                          issue_kind,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] issue_rs1,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] issue_rs2,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] issue_rd,
    output logic                                 issue_wr,
    input  logic                                 wb_valid,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] wb_rd,
    input  logic                                 flush,
    output logic                                 sb_error
`ifdef ISSUE_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                          stall_cycles,
    output logic [31:0]                          issue_count
`endif
);

    localparam int CW = pend_count_width(MAX_PENDING);

    logic [CW-1:0] eff_rs1;
    logic [CW-1:0] eff_rs2;
    logic [CW-1:0] eff_rd;
    logic          raw_hazard;
    logic          sat_hazard;
    logic          hazard;
    logic          accept;
    logic          inc_en;
    logic          rel_en;
    slot_state_t   state;
    slot_state_t   state_next;
    slot_t         slot;

    scoreboard_table #(
        .MAX_PENDING (MAX_PENDING),
        .ADDR_WIDTH  (REGISTER_DESCRIPTOR_WIDTH)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .addr_a   (rs1_addr),
        .addr_b   (rs2_addr),
        .addr_c   (rd_addr),
        .eff_a    (eff_rs1),
        .eff_b    (eff_rs2),
        .eff_c    (eff_rd),
        .inc_en   (inc_en),
        .inc_addr (rd_addr),
        .dec_en   (wb_valid),
        .dec_addr (wb_rd),
        .rel_en   (rel_en),
        .rel_addr (slot.rd),
        .sb_error (sb_error)
    );

    assign raw_hazard = (uses_rs1 && eff_rs1 != '0) || (uses_rs2 && eff_rs2 != '0);
    assign sat_hazard = write_reserve && rd_addr != '0 && eff_rd == CW'(MAX_PENDING);
    assign hazard     = raw_hazard || sat_hazard;
    assign dec_ready  = rst && !flush && !hazard && (state == SLOT_EMPTY || issue_ready);
    assign accept     = dec_valid && dec_ready;
    assign inc_en     = accept && write_reserve && rd_addr != '0;
    assign rel_en     = flush && state == SLOT_FULL && slot.wr && slot.rd != '0;

    // Slot state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Slot next state: flush wins, then accept fills, otherwise a take drains.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = SLOT_EMPTY;
        end else if (accept) begin
            state_next = SLOT_FULL;
        end else if (state == SLOT_FULL && issue_ready) begin
            state_next = SLOT_EMPTY;
        end
    end

    // Slot payload only changes on accept, so it holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot <= '0;
        end else if (accept) begin
            slot <= '{kind: instr_kind, rs1: rs1_addr, rs2: rs2_addr, rd: rd_addr, wr: write_reserve};
        end
    end

    assign issue_valid = state == SLOT_FULL;
    assign issue_kind  = slot.kind;
    assign issue_rs1   = slot.rs1;
    assign issue_rs2   = slot.rs2;
    assign issue_rd    = slot.rd;
    assign issue_wr    = slot.wr;

`ifdef ISSUE_SCOREBOARD_STATS_EN
    // Free-running stall and issue counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            issue_count  <= '0;
        end else begin
            if (dec_valid && hazard) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (accept) begin
                issue_count <= issue_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard (default MAX_PENDING=3).
// Inputs change on the falling edge; combinational outputs are checked 1ns
// later and registered outputs right at the falling edge.
module tb_issue_scoreboard;

    import instr_type::*;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    instr_kind_t instr_kind;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        write_reserve;
    logic        issue_valid;
    logic        issue_ready;
    instr_kind_t issue_kind;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_wr;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        sb_error;
`ifdef ISSUE_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] issue_count;
`endif

    int checks   = 0;
    int failures = 0;

    issue_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .instr_kind    (instr_kind),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .uses_rs1      (uses_rs1),
        .uses_rs2      (uses_rs2),
        .write_reserve (write_reserve),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_kind    (issue_kind),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_wr      (issue_wr),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .sb_error      (sb_error)
`ifdef ISSUE_SCOREBOARD_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .issue_count   (issue_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input instr_kind_t k, input logic v,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                 input logic u1, input logic u2, input logic wr);
        instr_kind    = k;
        dec_valid     = v;
        rs1_addr      = r1;
        rs2_addr      = r2;
        rd_addr       = rd;
        uses_rs1      = u1;
        uses_rs2      = u2;
        write_reserve = wr;
    endtask

    task automatic setWb(input logic v, input logic [4:0] r);
        wb_valid = v;
        wb_rd    = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst         = 1'b0;
        issue_ready = 1'b0;
        flush       = 1'b0;
        setWb(1'b0, 5'd0);
        applyStimulus(Alu, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);

        // Reset behaviour
        @(negedge clk);
        #1 checkOutput("reset_dec_ready", 32'(dec_ready), 32'd0);
        @(negedge clk);
        checkOutput("reset_issue_valid", 32'(issue_valid), 32'd0);
        checkOutput("reset_issue_kind", 32'(issue_kind), 32'(Invalid));
        checkOutput("reset_issue_rd", 32'(issue_rd), 32'd0);
        checkOutput("reset_sb_error", 32'(sb_error), 32'd0);
        rst         = 1'b1;
        issue_ready = 1'b1;

        // Independent ADDI x1, ADDI x2 stream
        applyStimulus(AluImm, 1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1);
        #1 checkOutput("t1_ready_x1", 32'(dec_ready), 32'd1);
        @(negedge clk);
        checkOutput("t1_issue_valid_x1", 32'(issue_valid), 32'd1);
        checkOutput("t1_issue_rd_x1", 32'(issue_rd), 32'd1);
        applyStimulus(AluImm, 1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1);
        #1 checkOutput("t1_ready_x2", 32'(dec_ready), 32'd1);
        @(negedge clk);
        checkOutput("t1_issue_rd_x2", 32'(issue_rd), 32'd2);
        checkOutput("t1_issue_kind_x2", 32'(issue_kind), 32'(AluImm));
        applyStimulus(Alu, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("t1_pend1_busy", 32'(dec_ready), 32'd0);
        applyStimulus(Alu, 1'b0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("t1_pend2_busy", 32'(dec_ready), 32'd0);
        @(negedge clk);
        checkOutput("t1_slot_drained", 32'(issue_valid), 32'd0);
        setWb(1'b1, 5'd1);
        applyStimulus(Alu, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("t1_wb_bypass_x1", 32'(dec_ready), 32'd1);
        @(negedge clk);
        setWb(1'b1, 5'd2);
        #1 checkOutput("t1_pend1_clear", 32'(dec_ready), 32'd1);
        @(negedge clk);
        setWb(1'b0, 5'd0);
        applyStimulus(Alu, 1'b0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("t1_pend2_clear", 32'(dec_ready), 32'd1);

        // Dependent pair: ADD x3, then SUB x4 = x3 - x5
        applyStimulus(Alu, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
        #1 checkOutput("t2_ready_add", 32'(dec_ready), 32'd1);
        @(negedge clk);
        checkOutput("t2_issue_rd_add", 32'(issue_rd), 32'd3);
        applyStimulus(Alu, 1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1);
        #1 checkOutput("t2_stall_1", 32'(dec_ready), 32'd0);
        @(negedge clk);
        #1 checkOutput("t2_stall_2", 32'(dec_ready), 32'd0);
        @(negedge clk);
        setWb(1'b1, 5'd3);
        #1 checkOutput("t2_wb_accept", 32'(dec_ready), 32'd1);
        @(negedge clk);
        setWb(1'b0, 5'd0);
        checkOutput("t2_issue_valid_sub", 32'(issue_valid), 32'd1);
        checkOutput("t2_issue_rd_sub", 32'(issue_rd), 32'd4);
        checkOutput("t2_issue_rs1_sub", 32'(issue_rs1), 32'd3);
        checkOutput("t2_issue_rs2_sub", 32'(issue_rs2), 32'd5);
`ifdef ISSUE_SCOREBOARD_STATS_EN
        checkOutput("t2_stall_cycles", stall_cycles, 32'd2);
        checkOutput("t2_issue_count", issue_count, 32'd4);
`endif
        applyStimulus(Alu, 1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("t2_pend4_busy", 32'(dec_ready), 32'd0);
        applyStimulus(Alu, 1'b0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("t2_pend3_clear", 32'(dec_ready), 32'd1);
        @(negedge clk);
        setWb(1'b1, 5'd4);
        @(negedge clk);
        setWb(1'b0, 5'd0);

        // Saturation: four writes to x7 with MAX_PENDING=3
        applyStimulus(AluImm, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("t3_ready_fill", 32'(dec_ready), 32'd1);
            @(negedge clk);
        end
        #1 checkOutput("t3_saturated", 32'(dec_ready), 32'd0);
        @(negedge clk);
        setWb(1'b1, 5'd7);
        #1 checkOutput("t3_wb_accept", 32'(dec_ready), 32'd1);
        @(negedge clk);
        setWb(1'b0, 5'd0);
        applyStimulus(AluImm, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
        #1 checkOutput("t3_still_three", 32'(dec_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            setWb(1'b1, 5'd7);
            @(negedge clk);
        end
        setWb(1'b0, 5'd0);
        applyStimulus(Alu, 1'b0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("t3_pend7_clear", 32'(dec_ready), 32'd1);

        // Flush of a held slot releases its reservation
        issue_ready = 1'b0;
        applyStimulus(Load, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
        #1 checkOutput("t4_ready_load", 32'(dec_ready), 32'd1);
        @(negedge clk);
        applyStimulus(Alu, 1'b0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_issue_valid", 32'(issue_valid), 32'd1);
        checkOutput("t4_issue_kind", 32'(issue_kind), 32'(Load));
        #1 checkOutput("t4_pend9_busy", 32'(dec_ready), 32'd0);
        @(negedge clk);
        checkOutput("t4_hold_rd", 32'(issue_rd), 32'd9);
        checkOutput("t4_hold_wr", 32'(issue_wr), 32'd1);
        applyStimulus(Alu, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        issue_ready = 1'b1;
        flush       = 1'b1;
        #1 checkOutput("t4_flush_ready", 32'(dec_ready), 32'd0);
        @(negedge clk);
        flush       = 1'b0;
        issue_ready = 1'b0;
        checkOutput("t4_flushed_valid", 32'(issue_valid), 32'd0);
        applyStimulus(Alu, 1'b0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("t4_pend9_released", 32'(dec_ready), 32'd1);

        // Writeback underflow: x0 ignored, x12 flags sticky error
        setWb(1'b1, 5'd0);
        @(negedge clk);
        checkOutput("t5_x0_no_error", 32'(sb_error), 32'd0);
        setWb(1'b1, 5'd12);
        @(negedge clk);
        setWb(1'b0, 5'd0);
        checkOutput("t5_x12_error", 32'(sb_error), 32'd1);
        @(negedge clk);
        checkOutput("t5_error_sticky", 32'(sb_error), 32'd1);

        // Reset mid-operation with pend[5]=2 and slot full
        applyStimulus(AluImm, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        issue_ready = 1'b1;
        #1 checkOutput("t6_ready_second", 32'(dec_ready), 32'd1);
        @(negedge clk);
        issue_ready = 1'b0;
        checkOutput("t6_slot_full", 32'(issue_valid), 32'd1);
        applyStimulus(Alu, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("t6_pend5_busy", 32'(dec_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_reset_valid", 32'(issue_valid), 32'd0);
        checkOutput("t6_reset_kind", 32'(issue_kind), 32'(Invalid));
        checkOutput("t6_reset_error", 32'(sb_error), 32'd0);
        rst = 1'b1;
        #1 checkOutput("t6_pend5_dropped", 32'(dec_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
